// File: rtl/pwr_cnt_cmp.sv
// Run counter with inhibit/clear/stop/load gating and a terminal-count FSM, plus an
// independent registered magnitude comparator. Every output is a flop.
module pwr_cnt_cmp #(
    parameter int WIDTH    = 9,
    parameter int CMP_W    = 4,
    parameter int SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             inhibit,
    input  logic             clr_a,
    input  logic             clr_b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             cmp_en,
    input  logic [CMP_W-1:0] cmp_a,
    input  logic [CMP_W-1:0] cmp_b,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             tc,
    output logic             done,
    output logic             cmp_eq,
    output logic             cmp_gt
);

    // state   | meaning
    // S_IDLE  | waiting for start, count held
    // S_RUN   | counting toward limit
    // S_PAUSE | inhibited, count held
    // S_DONE  | saturated at limit (SAT_MODE=1 only)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_cmp_eq;
    logic             r_cmp_gt;
    logic             w_clear;

    assign w_clear = clr_a & clr_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Priority: clear, then load, then stop (only meaningful in RUN/PAUSE), then the FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        if (w_clear) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
        end else if (load) begin
            w_count_nxt = load_val;
        end else if (stop && (r_state == S_RUN || r_state == S_PAUSE)) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_RUN;
                        w_count_nxt = '0;
                    end
                end
                S_RUN: begin
                    if (inhibit) begin
                        w_state_nxt = S_PAUSE;
                    end else if (r_count != limit) begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end else if (SAT_MODE == 0) begin
                        w_count_nxt = '0;
                        w_tc_nxt    = 1'b1;
                    end else begin
                        w_tc_nxt    = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
                S_PAUSE: begin
                    if (!inhibit) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_eq <= 1'b0;
            r_cmp_gt <= 1'b0;
        end else begin
            r_cmp_eq <= cmp_en & (cmp_a == cmp_b);
            r_cmp_gt <= cmp_en & (cmp_a > cmp_b);
        end
    end

    assign count  = r_count;
    assign state  = r_state;
    assign tc     = r_tc;
    assign done   = r_done;
    assign cmp_eq = r_cmp_eq;
    assign cmp_gt = r_cmp_gt;

endmodule

// File: tb/tb_pwr_cnt_cmp.sv
// Bench for pwr_cnt_cmp: wrap and saturate instances driven in parallel, checked
// against a cycle-level behavioural model, with directed scenarios then random stimulus.
module tb_pwr_cnt_cmp;
    localparam int W  = 9;
    localparam int CW = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, inhibit, clr_a, clr_b, load, cmp_en;
    logic [W-1:0]  load_val, limit;
    logic [CW-1:0] cmp_a, cmp_b;
    logic [W-1:0]  count0, count1;
    logic [1:0]    state0, state1;
    logic          tc0, tc1, done0, done1, eq0, eq1, gt0, gt1;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt[2], m_st[2], m_tc[2], m_done[2];
    int m_eq, m_gt;

    always #5 clk = ~clk;

    pwr_cnt_cmp #(.WIDTH(W), .CMP_W(CW), .SAT_MODE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .inhibit(inhibit),
        .clr_a(clr_a), .clr_b(clr_b), .load(load), .load_val(load_val), .limit(limit),
        .cmp_en(cmp_en), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .count(count0), .state(state0), .tc(tc0), .done(done0), .cmp_eq(eq0), .cmp_gt(gt0)
    );

    pwr_cnt_cmp #(.WIDTH(W), .CMP_W(CW), .SAT_MODE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .inhibit(inhibit),
        .clr_a(clr_a), .clr_b(clr_b), .load(load), .load_val(load_val), .limit(limit),
        .cmp_en(cmp_en), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .count(count1), .state(state1), .tc(tc1), .done(done1), .cmp_eq(eq1), .cmp_gt(gt1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cnt[s] = 0; m_st[s] = M_IDLE; m_tc[s] = 0; m_done[s] = 0;
        end
        m_eq = 0; m_gt = 0;
    endtask

    // One active edge of the reference; s=1 is the saturating instance.
    task automatic model_edge(input int s);
        int c, st, lim;
        c = m_cnt[s]; st = m_st[s]; lim = int'(limit);
        m_tc[s] = 0; m_done[s] = 0;
        if (clr_a && clr_b) begin
            c = 0; st = M_IDLE;
        end else if (load) begin
            c = int'(load_val);
        end else if (stop && (st == M_RUN || st == M_PAUSE)) begin
            st = M_IDLE;
        end else if ((st == M_IDLE || st == M_DONE) && start) begin
            st = M_RUN; c = 0;
        end else if (st == M_PAUSE && !inhibit) begin
            st = M_RUN;
        end else if (st == M_RUN && inhibit) begin
            st = M_PAUSE;
        end else if (st == M_RUN) begin
            if (c == lim) begin
                m_tc[s] = 1;
                if (s == 1) begin m_done[s] = 1; st = M_DONE; end
                else c = 0;
            end else begin
                c = (c + 1) % (1 << W);
            end
        end
        m_cnt[s] = c; m_st[s] = st;
    endtask

    task automatic check_all();
        chk("count_wrap", 32'(count0), m_cnt[0]);
        chk("state_wrap", 32'(state0), m_st[0]);
        chk("tc_wrap",    32'(tc0),    m_tc[0]);
        chk("done_wrap",  32'(done0),  m_done[0]);
        chk("count_sat",  32'(count1), m_cnt[1]);
        chk("state_sat",  32'(state1), m_st[1]);
        chk("tc_sat",     32'(tc1),    m_tc[1]);
        chk("done_sat",   32'(done1),  m_done[1]);
        chk("cmp_eq",     32'(eq0),    m_eq);
        chk("cmp_gt",     32'(gt0),    m_gt);
        chk("cmp_eq_sat", 32'(eq1),    m_eq);
        chk("cmp_gt_sat", 32'(gt1),    m_gt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        m_eq = (cmp_en && cmp_a == cmp_b) ? 1 : 0;
        m_gt = (cmp_en && cmp_a > cmp_b) ? 1 : 0;
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; inhibit = 0; clr_a = 0; clr_b = 0; load = 0;
        load_val = '0; cmp_en = 0; cmp_a = '0; cmp_b = '0;
    endtask

    initial begin
        idle_inputs();
        limit = 9'd5;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: wrap at limit 5
        start = 1; step();
        chk("t1_start_cnt", 32'(count0), 0);
        chk("t1_start_state", 32'(state0), 1);
        start = 0; steps(5);
        chk("t1_cnt5", 32'(count0), 5);
        chk("t1_no_tc", 32'(tc0), 0);
        step();
        chk("t1_wrap_cnt", 32'(count0), 0);
        chk("t1_wrap_tc", 32'(tc0), 1);
        chk("t1_wrap_state", 32'(state0), 1);
        step();
        chk("t1_tc_drop", 32'(tc0), 0);

        // 2: saturate at limit 3
        clr_a = 1; clr_b = 1; step();
        clr_a = 0; clr_b = 0; limit = 9'd3;
        start = 1; step();
        start = 0; steps(3);
        chk("t2_cnt3", 32'(count1), 3);
        step();
        chk("t2_done_state", 32'(state1), 3);
        chk("t2_done_pulse", 32'(done1), 1);
        chk("t2_tc_pulse", 32'(tc1), 1);
        step();
        chk("t2_done_once", 32'(done1), 0);
        chk("t2_hold", 32'(count1), 3);
        start = 1; step();
        start = 0;
        chk("t2_restart_cnt", 32'(count1), 0);
        chk("t2_restart_state", 32'(state1), 1);

        // 3: pause/resume/stop
        load = 1; load_val = 9'd7; step();
        load = 0; inhibit = 1; steps(3);
        chk("t3_pause", 32'(state0), 2);
        chk("t3_hold7", 32'(count0), 7);
        inhibit = 0; step();
        chk("t3_resume_cnt", 32'(count0), 7);
        step();
        chk("t3_cnt8", 32'(count0), 8);
        stop = 1; step();
        stop = 0;
        chk("t3_stop_state", 32'(state0), 0);
        chk("t3_stop_cnt", 32'(count0), 8);

        // 4: clear qualification and priority over load
        start = 1; step();
        start = 0; clr_a = 1; step();
        chk("t4_half_clr", 32'(count0), 1);
        clr_b = 1; load = 1; load_val = 9'd100; step();
        chk("t4_clr_cnt", 32'(count0), 0);
        chk("t4_clr_state", 32'(state0), 0);
        clr_a = 0; clr_b = 0; load = 0;
        start = 1; step();
        start = 0; load = 1; step();
        load = 0;
        chk("t4_load", 32'(count0), 100);
        step();
        chk("t4_load_inc", 32'(count0), 101);

        // 5: count above limit wraps through all-ones without tc
        limit = 9'd10; load = 1; load_val = 9'd500; step();
        load = 0; steps(11);
        chk("t5_allones", 32'(count0), 511);
        step();
        chk("t5_nat_wrap", 32'(count0), 0);
        chk("t5_nat_no_tc", 32'(tc0), 0);
        steps(10);
        step();
        chk("t5_tc", 32'(tc0), 1);

        // 6: comparator
        cmp_en = 1; cmp_a = 4'd9; cmp_b = 4'd9; step();
        chk("t6_eq", 32'(eq0), 1);
        chk("t6_eq_gt", 32'(gt0), 0);
        cmp_a = 4'd12; cmp_b = 4'd3; #1;
        chk("t6_latency", 32'(eq0), 1);
        step();
        chk("t6_gt", 32'(gt0), 1);
        chk("t6_gt_eq", 32'(eq0), 0);
        cmp_en = 0; step();
        chk("t6_dis_eq", 32'(eq0), 0);
        chk("t6_dis_gt", 32'(gt0), 0);

        // random phase, including occasional asynchronous reset mid-cycle
        for (int i = 0; i < 3000; i++) begin
            start   = ($urandom_range(0, 4) == 0);
            stop    = ($urandom_range(0, 19) == 0);
            inhibit = ($urandom_range(0, 4) == 0);
            clr_a   = ($urandom_range(0, 7) == 0);
            clr_b   = ($urandom_range(0, 7) == 0);
            load    = ($urandom_range(0, 24) == 0);
            load_val = W'($urandom_range(0, 511));
            if ($urandom_range(0, 15) == 0)
                limit = ($urandom_range(0, 9) < 7) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 511));
            cmp_en = ($urandom_range(0, 3) != 0);
            cmp_a  = CW'($urandom_range(0, 15));
            cmp_b  = ($urandom_range(0, 3) == 0) ? cmp_a : CW'($urandom_range(0, 15));
            step();
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                #1 rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
